// File: rtl/code_pkg.sv
// Shared types and defaults for the keypad-lock code sender and the lock it talks to.
package code_pkg;

  typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT, LOCKOUT} sender_state_t;

  localparam int DEF_DIGIT_W        = 4;
  localparam int DEF_NUM_DIGITS     = 4;
  localparam int DEF_LOCKOUT_CYCLES = 31;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/code_sender_if.sv
// Digit-interface bundle between the code sender (master) and its user/lock side (slave).
interface code_sender_if
  import code_pkg::*;
#(
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int MAX_FAILS  = 4
);
  localparam int FC_W = $clog2(MAX_FAILS + 1);

  logic                          start;
  logic [NUM_DIGITS*DIGIT_W-1:0] code;
  logic                          unlock_in;
  logic [DIGIT_W-1:0]            digit_out;
  logic                          digit_valid;
  logic                          busy;
  logic                          done;
  logic                          success;
  logic                          locked_out;
  logic [FC_W-1:0]               fail_count;

  modport master (
    input  start, code, unlock_in,
    output digit_out, digit_valid, busy, done, success, locked_out, fail_count
  );

  modport slave (
    output start, code, unlock_in,
    input  digit_out, digit_valid, busy, done, success, locked_out, fail_count
  );

endinterface

// File: rtl/sender_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module sender_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);
  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst)
      count_reg <= '0;
    else if (load)
      count_reg <= load_val;
    else if (count_reg != '0)
      count_reg <= count_reg - 1'b1;
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/code_sender.sv
// Sends a latched access code digit by digit, waits for unlock, tracks failures and lockout.
// Optional feature: CODE_SENDER_AUTO_RETRY_EN re-sends the latched code after a non-lockout failure.
module code_sender
  import code_pkg::*;
#(
  parameter int DIGIT_W        = DEF_DIGIT_W,
  parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int GAP_CYCLES     = 2,
  parameter int RESP_TIMEOUT   = 8,
  parameter int MAX_FAILS      = 4,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic           clk,
  input  logic           rst,
  code_sender_if.master  bus
);
  localparam int FC_W    = $clog2(MAX_FAILS + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TIMER_W = $clog2(max3(GAP_CYCLES, RESP_TIMEOUT, LOCKOUT_CYCLES) + 1);

  // Timer counts down to zero, so each interval loads its length minus one.
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(RESP_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]    FAIL_MAX  = FC_W'(MAX_FAILS);
  localparam logic [FC_W-1:0]    FAIL_LAST = FC_W'(MAX_FAILS - 1);

`ifdef CODE_SENDER_AUTO_RETRY_EN
  localparam sender_state_t FAIL_STATE = SEND;
`else
  localparam sender_state_t FAIL_STATE = IDLE;
`endif

  sender_state_t                 state_reg, state_next;
  logic [NUM_DIGITS*DIGIT_W-1:0] code_reg, code_next;
  logic [IDX_W-1:0]              idx_reg, idx_next;
  logic [FC_W-1:0]               fail_count_reg, fail_count_next;
  logic                          timer_load;
  logic [TIMER_W-1:0]            timer_val;
  logic                          timer_zero;
  logic                          done_c, success_c;
  logic [DIGIT_W-1:0]            digits [NUM_DIGITS];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digits[gi] = code_reg[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  sender_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      code_reg       <= '0;
      idx_reg        <= '0;
      fail_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      code_reg       <= code_next;
      idx_reg        <= idx_next;
      fail_count_reg <= fail_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    code_next       = code_reg;
    idx_next        = idx_reg;
    fail_count_next = fail_count_reg;
    timer_load      = 1'b0;
    timer_val       = '0;
    done_c          = 1'b0;
    success_c       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          code_next  = bus.code;
          idx_next   = '0;
          timer_load = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (idx_reg == LAST_IDX) begin
          timer_load = 1'b1;
          timer_val  = WAIT_LOAD;
          state_next = WAIT;
        end else if (GAP_CYCLES == 0) begin
          idx_next = idx_reg + 1'b1;
        end else begin
          timer_load = 1'b1;
          timer_val  = GAP_LOAD;
          state_next = GAP;
        end
      end
      GAP: begin
        if (timer_zero) begin
          idx_next   = idx_reg + 1'b1;
          timer_load = 1'b1;
          state_next = SEND;
        end
      end
      WAIT: begin
        // unlock_in wins over a simultaneous timeout.
        if (bus.unlock_in) begin
          done_c          = 1'b1;
          success_c       = 1'b1;
          fail_count_next = '0;
          idx_next        = '0;
          state_next      = IDLE;
        end else if (timer_zero) begin
          done_c   = 1'b1;
          idx_next = '0;
          if (fail_count_reg >= FAIL_LAST) begin
            fail_count_next = FAIL_MAX;
            timer_load      = 1'b1;
            timer_val       = LOCK_LOAD;
            state_next      = LOCKOUT;
          end else begin
            fail_count_next = fail_count_reg + 1'b1;
            timer_load      = 1'b1;
            state_next      = FAIL_STATE;
          end
        end
      end
      LOCKOUT: begin
        if (timer_zero) begin
          fail_count_next = '0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.digit_valid = (state_reg == SEND);
  assign bus.digit_out   = (state_reg == SEND) ? digits[idx_reg] : '0;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.locked_out  = (state_reg == LOCKOUT);
  assign bus.done        = done_c;
  assign bus.success     = success_c;
  assign bus.fail_count  = fail_count_reg;

endmodule
